// File: rtl/frequency_generator.sv
// frequency_generator: programmable 50% duty square-wave source with iterative half-period divider
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-low reset
//   freq_in    in  requested frequency in Hz, 0 stops the output
//   freq_valid in  request strobe, taken when freq_ready is high
//   freq_ready out ready to accept a request (FSM idle)
//   busy       out divider running
//   active     out generator toggling
//   signal_out out registered square wave
module frequency_generator #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BIT_SIZE  = 20,
    parameter int CNT_WIDTH = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIT_SIZE-1:0] freq_in,
    input  logic                freq_valid,
    output logic                freq_ready,
    output logic                busy,
    output logic                active,
    output logic                signal_out
);
    localparam int IW = $clog2(CNT_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] DIVIDEND = CNT_WIDTH'(CLK_FREQ);
    localparam logic [IW-1:0] LAST = IW'(CNT_WIDTH - 1);

    typedef enum logic {IDLE, DIVIDE} state_t;
    state_t state_q, state_d;

    logic [BIT_SIZE:0]   divisor_q, rem_q, rem_d;
    logic [BIT_SIZE+1:0] rem_shift, trial;
    logic [CNT_WIDTH-1:0] dq_q, quo_d, half_new;
    logic [CNT_WIDTH-1:0] pend_q, half_q, cnt_q;
    logic [IW-1:0]       iter_q;
    logic                pend_vld_q, active_q, sig_q;
    logic                accept, start, stop, last_iter, fits, toggle;

    assign accept    = freq_valid & freq_ready;
    assign start     = accept & (freq_in != '0);
    assign stop      = accept & (freq_in == '0);
    assign last_iter = (state_q == DIVIDE) & (iter_q == LAST);
    assign toggle    = active_q & (cnt_q == half_q - CNT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (start ? DIVIDE : IDLE) : (last_iter ? IDLE : DIVIDE);
    end

    always_comb begin
        busy       = state_q == DIVIDE;
        freq_ready = state_q == IDLE;
    end

    // Restoring step: the sign of (rem*2+bit - divisor) decides the quotient bit.
    // dq_q shifts dividend bits out of its MSB while quotient bits enter its LSB.
    always_comb begin
        rem_shift = {rem_q, dq_q[CNT_WIDTH-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        fits      = ~trial[BIT_SIZE+1];
        rem_d     = fits ? trial[BIT_SIZE:0] : rem_shift[BIT_SIZE:0];
        quo_d     = {dq_q[CNT_WIDTH-2:0], fits};
        half_new  = (quo_d == '0) ? CNT_WIDTH'(1) : quo_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divisor_q  <= '0;
            rem_q      <= '0;
            dq_q       <= '0;
            iter_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            half_q     <= '0;
            cnt_q      <= '0;
            active_q   <= 1'b0;
            sig_q      <= 1'b0;
        end else begin
            if (start) begin
                divisor_q <= {freq_in, 1'b0};
                rem_q     <= '0;
                dq_q      <= DIVIDEND;
                iter_q    <= '0;
            end else if (busy) begin
                rem_q  <= rem_d;
                dq_q   <= quo_d;
                iter_q <= iter_q + IW'(1);
            end
            if (stop) begin
                active_q   <= 1'b0;
                sig_q      <= 1'b0;
                cnt_q      <= '0;
                pend_vld_q <= 1'b0;
            end else if (active_q) begin
                cnt_q <= toggle ? '0 : cnt_q + CNT_WIDTH'(1);
                if (toggle) begin
                    sig_q <= ~sig_q;
                    if (pend_vld_q) begin
                        half_q     <= pend_q;
                        pend_vld_q <= 1'b0;
                    end
                end
            end else if (pend_vld_q) begin
                half_q     <= pend_q;
                pend_vld_q <= 1'b0;
                active_q   <= 1'b1;
                cnt_q      <= '0;
                sig_q      <= 1'b0;
            end
            // A freshly divided value overrides any consumption in the same cycle: last value wins.
            if (last_iter) begin
                pend_q     <= half_new;
                pend_vld_q <= 1'b1;
            end
        end
    end

    assign active     = active_q;
    assign signal_out = sig_q;
endmodule
